// File: rtl/rv_dmem_responder.sv
// Data-memory responder: valid/ready request and response channels
// around a word RAM, with configurable latency and error reporting.
module rv_dmem_responder #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_we,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam bit LAT0 = (LATENCY == 0);
    localparam logic [3:0] LAT_INIT =
        LAT0 ? 4'd0 : 4'(LATENCY - 1);
    localparam logic [ADDR_W-2:0] WORD_LIM = (ADDR_W-1)'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic [3:0]        r_cnt;
    logic              r_resp_valid;
    logic [31:0]       r_rdata;
    logic              r_err;
    logic [31:0]       r_mem [DEPTH_WORDS];

    logic              w_accept;
    logic              w_enter_resp;
    logic [ADDR_W-1:0] w_addr;
    logic              w_we;
    logic [31:0]       w_wdata;
    logic [3:0]        w_wstrb;
    logic [ADDR_W-3:0] w_word;
    logic [IDX_W-1:0]  w_idx;
    logic              w_err;

    assign w_accept = (r_state == S_IDLE) && req_valid && !rst;

    // With zero latency the commit uses the request as it is being accepted.
    assign w_enter_resp = !rst &&
        ((w_accept && LAT0) || (r_state == S_WAIT && r_cnt == 4'd0));

    assign w_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
    assign w_we    = (r_state == S_IDLE) ? req_we    : r_we;
    assign w_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
    assign w_wstrb = (r_state == S_IDLE) ? req_wstrb : r_wstrb;

    assign w_word = w_addr[ADDR_W-1:2];
    assign w_idx  = w_word[IDX_W-1:0];
    assign w_err  = (w_addr[1:0] != 2'b00) || ({1'b0, w_word} >= WORD_LIM);

    assign req_ready  = (r_state == S_IDLE) && !rst;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    always_ff @(posedge clk) begin
        if (w_enter_resp && w_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wstrb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
        end else begin
            if (w_enter_resp) begin
                r_state      <= S_RESP;
                r_resp_valid <= 1'b1;
                r_err        <= w_err;
                r_rdata      <= (!w_we && !w_err) ? r_mem[w_idx] : '0;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= req_addr;
                        r_we    <= req_we;
                        r_wdata <= req_wdata;
                        r_wstrb <= req_wstrb;
                        if (!LAT0) begin
                            r_state <= S_WAIT;
                            r_cnt   <= LAT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_dmem_responder.sv
// Directed bench for rv_dmem_responder: vector table plus
// backpressure, mid-operation reset and zero-latency sequences.
module tb_rv_dmem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        z_req_valid;
    logic        z_req_ready;
    logic [31:0] z_req_addr;
    logic        z_req_we;
    logic [31:0] z_req_wdata;
    logic [3:0]  z_req_wstrb;
    logic        z_resp_valid;
    logic        z_resp_ready;
    logic [31:0] z_resp_rdata;
    logic        z_resp_err;

    int total = 0;
    int bad   = 0;

    rv_dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_we(req_we),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    rv_dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(1024), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready),
        .req_addr(z_req_addr), .req_we(z_req_we),
        .req_wdata(z_req_wdata), .req_wstrb(z_req_wstrb),
        .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
        .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic txn(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       output logic [31:0] rd, output logic er,
                       output int lat, output bit to);
        int n;
        to = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = strb;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) to = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        rd  = '0;
        er  = 1'b0;
        while (!to) begin
            @(negedge clk);
            lat++;
            if (resp_valid) break;
            if (lat > 40) to = 1'b1;
        end
        if (!to) begin
            rd = resp_rdata;
            er = resp_err;
            resp_ready = 1'b1;
            @(posedge clk);
            #1 resp_ready = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        bit          to;
        int          n;
        logic [31:0] held;
        logic [31:0] z_exp [2];

        vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h10,  32'h11223344, 4'h5, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDE22BE44, 1'b0};
        vecs[4]  = '{1'b0, 32'h13,  32'h0,        4'h0, 32'h0,        1'b1};
        vecs[5]  = '{1'b1, 32'h0,   32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
        vecs[6]  = '{1'b1, 32'h1000,32'h12345678, 4'hF, 32'h0,        1'b1};
        vecs[7]  = '{1'b0, 32'h0,   32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
        vecs[8]  = '{1'b1, 32'h10,  32'hAABBCCDD, 4'h0, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDE22BE44, 1'b0};
        vecs[10] = '{1'b1, 32'hFFC, 32'h01020304, 4'hF, 32'h0,        1'b0};
        vecs[11] = '{1'b0, 32'hFFC, 32'h0,        4'h0, 32'h01020304, 1'b0};
        vecs[12] = '{1'b1, 32'h22,  32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        vecs[13] = '{1'b1, 32'h20,  32'h0,        4'hF, 32'h0,        1'b0};

        rst = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_we = 1'b0;
        req_wdata = '0; req_wstrb = '0; resp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_addr = '0; z_req_we = 1'b0;
        z_req_wdata = '0; z_req_wstrb = '0; z_resp_ready = 1'b0;

        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("rst_req_ready%0d", c), 32'(req_ready), 32'd0);
            chk($sformatf("rst_resp_valid%0d", c), 32'(resp_valid), 32'd0);
            chk($sformatf("rst_rdata%0d", c), resp_rdata, 32'd0);
            chk($sformatf("rst_err%0d", c), 32'(resp_err), 32'd0);
        end
        rst = 1'b0;
        #1 chk("post_rst_req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 14; i++) begin
            txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
                rd, er, lat, to);
            chk($sformatf("v%0d_timeout", i), 32'(to), 32'd0);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
        end

        // response held under backpressure
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 40);
        chk("bp_valid_seen", 32'(resp_valid), 32'd1);
        held = resp_rdata;
        chk("bp_rdata", held, 32'hDE22BE44);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_valid%0d", c), 32'(resp_valid), 32'd1);
            chk($sformatf("bp_stable%0d", c), resp_rdata, held);
            chk($sformatf("bp_req_ready%0d", c), 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        chk("bp_hs_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk("bp_after_req_ready", 32'(req_ready), 32'd1);
        chk("bp_after_valid", 32'(resp_valid), 32'd0);

        // reset while a store waits: it must never commit
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20;
        req_wdata = 32'hFFFFFFFF; req_wstrb = 4'hF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            if (resp_valid) n++;
            @(negedge clk);
        end
        chk("mid_rst_no_resp", 32'(n), 32'd0);
        txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, to);
        chk("mid_rst_timeout", 32'(to), 32'd0);
        chk("mid_rst_load", rd, 32'h0);

        // zero-latency instance: store then load
        z_exp[0] = 32'h0;
        z_exp[1] = 32'h5A5A1234;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            chk($sformatf("z%0d_req_ready", t), 32'(z_req_ready), 32'd1);
            z_req_valid = 1'b1;
            z_req_we    = (t == 0);
            z_req_addr  = 32'h40;
            z_req_wdata = 32'h5A5A1234;
            z_req_wstrb = 4'hF;
            @(posedge clk);
            #1 z_req_valid = 1'b0;
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!z_resp_valid && lat < 40);
            chk($sformatf("z%0d_latency", t), 32'(lat), 32'd1);
            chk($sformatf("z%0d_rdata", t), z_resp_rdata, z_exp[t]);
            chk($sformatf("z%0d_err", t), 32'(z_resp_err), 32'd0);
            z_resp_ready = 1'b1;
            @(posedge clk);
            #1 z_resp_ready = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
